// File: rtl/gpio_bank_ctrl_pkg.sv
// Shared types for the GPIO bank: command opcodes, decoder states and
// the payload-size helper used to derive byte counts from the pin count.
package gpio_bank_ctrl_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [7:0] {
    OP_OUT       = 8'h01,
    OP_OE        = 8'h02,
    OP_RISE_MASK = 8'h03,
    OP_FALL_MASK = 8'h04,
    OP_IRQ_CLR   = 8'h05,
    OP_RD_SNAP   = 8'h06,
    OP_ERR_CLR   = 8'h07
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_EXEC
  } state_t;

  function automatic int nbytes(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/gpio_bank_ctrl_if.sv
// Byte command stream from the deframer plus the read-back FIFO port.
interface gpio_bank_ctrl_if;
  import gpio_bank_ctrl_pkg::*;

  logic  cmd_wr_en;
  byte_t cmd_byte;
  logic  rd_fifo_en;
  byte_t rd_fifo_data;
  logic  rd_fifo_empty;
  logic  rd_fifo_full;

  modport master (
    output cmd_wr_en, cmd_byte, rd_fifo_en,
    input  rd_fifo_data, rd_fifo_empty, rd_fifo_full
  );

  modport slave (
    input  cmd_wr_en, cmd_byte, rd_fifo_en,
    output rd_fifo_data, rd_fifo_empty, rd_fifo_full
  );

endinterface

// File: rtl/gpio_sync_fifo.sv
// Synchronous FIFO with registered read data; pointers carry an extra MSB
// so full and empty are distinguished without a separate counter.
module gpio_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic             ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push on full still lands.
  assign do_push = push && (!full || do_pop);
  assign ovf     = push && !do_push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop) begin
        rptr    <= rptr + (AW+1)'(1);
        rd_data <= mem[rptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/gpio_bank_ctrl.sv
// GPIO bank: byte-command decoder, per-pin OE/OUT and edge masks, synced
// inputs with sticky edge IRQs, and an input snapshot pusher into a byte FIFO.
module gpio_bank_ctrl
  import gpio_bank_ctrl_pkg::*;
#(
  parameter int GPIO_WIDTH = 12,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk1,
  input  logic                  rst_n,
  gpio_bank_ctrl_if.slave       bus,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic                  irq,
  output logic                  cmd_err,
  output logic                  rd_ovf
);

  localparam int NBYTES = nbytes(GPIO_WIDTH);
  localparam int SW     = NBYTES * 8;
  localparam int CW     = $clog2(NBYTES + 1);

  state_t                state;
  opcode_t               op;
  logic [SW-1:0]         shreg;
  logic [CW-1:0]         cnt;
  logic [GPIO_WIDTH-1:0] rise_mask;
  logic [GPIO_WIDTH-1:0] fall_mask;
  logic [GPIO_WIDTH-1:0] irq_status;
  logic [GPIO_WIDTH-1:0] sync1;
  logic [GPIO_WIDTH-1:0] sync2;
  logic [GPIO_WIDTH-1:0] prev;
  logic [GPIO_WIDTH-1:0] edges;
  logic [SW-1:0]         shadow;
  logic [CW-1:0]         push_left;
  logic                  push_busy;
  logic                  snap_start;
  logic                  exec_clr;
  logic                  fifo_drop;
  logic                  unused_shreg;

  assign push_busy  = (push_left != '0);
  assign snap_start = (state == ST_IDLE) && bus.cmd_wr_en &&
                      (bus.cmd_byte == OP_RD_SNAP) && !push_busy;
  assign exec_clr   = (state == ST_EXEC) && (op == OP_IRQ_CLR);
  assign edges      = (sync2 & ~prev & rise_mask) | (~sync2 & prev & fall_mask);
  assign unused_shreg = ^shreg;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op        <= OP_OUT;
      shreg     <= '0;
      cnt       <= '0;
      gpio_oe   <= '0;
      gpio_out  <= '0;
      rise_mask <= '0;
      fall_mask <= '0;
      cmd_err   <= 1'b0;
      rd_ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_wr_en) begin
            case (bus.cmd_byte)
              OP_OUT, OP_OE, OP_RISE_MASK, OP_FALL_MASK, OP_IRQ_CLR: begin
                op    <= opcode_t'(bus.cmd_byte);
                cnt   <= '0;
                state <= ST_PAYLOAD;
              end
              OP_RD_SNAP: if (push_busy) cmd_err <= 1'b1;
              OP_ERR_CLR: begin
                cmd_err <= 1'b0;
                rd_ovf  <= 1'b0;
              end
              default:    cmd_err <= 1'b1;
            endcase
          end
        end
        ST_PAYLOAD: begin
          if (bus.cmd_wr_en) begin
            // LSB byte arrives first, so bytes enter at the top and shift down.
            shreg <= (shreg >> 8) | (SW'(bus.cmd_byte) << (SW - 8));
            if (cnt == CW'(NBYTES - 1)) state <= ST_EXEC;
            else                        cnt   <= cnt + CW'(1);
          end
        end
        ST_EXEC: begin
          case (op)
            OP_OUT:       gpio_out  <= shreg[GPIO_WIDTH-1:0];
            OP_OE:        gpio_oe   <= shreg[GPIO_WIDTH-1:0];
            OP_RISE_MASK: rise_mask <= shreg[GPIO_WIDTH-1:0];
            OP_FALL_MASK: fall_mask <= shreg[GPIO_WIDTH-1:0];
            default:      ;
          endcase
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (fifo_drop) rd_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= '0;
      sync2      <= '0;
      prev       <= '0;
      irq_status <= '0;
      irq        <= 1'b0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
      prev  <= sync2;
      // New edges are OR-ed after the clear so a same-cycle edge survives.
      if (exec_clr) irq_status <= (irq_status & ~shreg[GPIO_WIDTH-1:0]) | edges;
      else          irq_status <= irq_status | edges;
      irq <= |irq_status;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= '0;
      push_left <= '0;
    end else if (snap_start) begin
      shadow    <= SW'(sync2);
      push_left <= CW'(NBYTES);
    end else if (push_busy) begin
      shadow    <= shadow >> 8;
      push_left <= push_left - CW'(1);
    end
  end

  gpio_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk1),
    .rst_n     (rst_n),
    .push      (push_busy),
    .push_data (shadow[7:0]),
    .pop       (bus.rd_fifo_en),
    .rd_data   (bus.rd_fifo_data),
    .empty     (bus.rd_fifo_empty),
    .full      (bus.rd_fifo_full),
    .ovf       (fifo_drop)
  );

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Directed and randomized checks of gpio_bank_ctrl against a command-level
// model: registers, sticky edge status, byte queue for read-back.
module tb_gpio_bank_ctrl;

  localparam int GW    = 12;
  localparam int DEPTH = 4;

  logic          clk1  = 1'b0;
  logic          rst_n = 1'b0;
  logic [GW-1:0] gpio_in;
  logic [GW-1:0] gpio_oe;
  logic [GW-1:0] gpio_out;
  logic          irq;
  logic          cmd_err;
  logic          rd_ovf;

  gpio_bank_ctrl_if bus ();

  gpio_bank_ctrl #(
    .GPIO_WIDTH (GW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk1     (clk1),
    .rst_n    (rst_n),
    .bus      (bus),
    .gpio_in  (gpio_in),
    .gpio_oe  (gpio_oe),
    .gpio_out (gpio_out),
    .irq      (irq),
    .cmd_err  (cmd_err),
    .rd_ovf   (rd_ovf)
  );

  always #5 clk1 = ~clk1;

  int n_assert = 0;
  int n_fail   = 0;

  logic [GW-1:0] m_oe, m_out, m_rise, m_fall, m_stat, pins;
  logic          m_err, m_ovf;
  logic [7:0]    m_data;
  logic [7:0]    q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic put(input logic [7:0] b);
    bus.cmd_wr_en = 1'b1;
    bus.cmd_byte  = b;
    step();
    bus.cmd_wr_en = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    put(b);
    step();
  endtask

  task automatic model_reset();
    m_oe = '0; m_out = '0; m_rise = '0; m_fall = '0; m_stat = '0;
    m_err = 1'b0; m_ovf = 1'b0; m_data = '0;
    q.delete();
  endtask

  task automatic model_push(input logic [7:0] b);
    if (q.size() < DEPTH) q.push_back(b);
    else                  m_ovf = 1'b1;
  endtask

  task automatic model_snap();
    logic [15:0] v;
    v = {4'b0, pins};
    model_push(v[7:0]);
    model_push(v[15:8]);
  endtask

  task automatic do_cmd(input logic [7:0] op, input logic [15:0] pl);
    send(op);
    send(pl[7:0]);
    send(pl[15:8]);
    step();
    case (op)
      8'h01: m_out  = pl[GW-1:0];
      8'h02: m_oe   = pl[GW-1:0];
      8'h03: m_rise = pl[GW-1:0];
      8'h04: m_fall = pl[GW-1:0];
      8'h05: m_stat = m_stat & ~pl[GW-1:0];
      default: ;
    endcase
  endtask

  task automatic snap();
    send(8'h06);
    step();
    model_snap();
  endtask

  task automatic set_pins(input logic [GW-1:0] v);
    gpio_in = v;
    m_stat  = m_stat | (v & ~pins & m_rise) | (~v & pins & m_fall);
    pins    = v;
    idle(5);
  endtask

  task automatic pop();
    bus.rd_fifo_en = 1'b1;
    step();
    bus.rd_fifo_en = 1'b0;
    if (q.size() > 0) m_data = q.pop_front();
  endtask

  task automatic check_all(input string t);
    chk({t, ".oe"},     32'(gpio_oe),            32'(m_oe));
    chk({t, ".out"},    32'(gpio_out),           32'(m_out));
    chk({t, ".status"}, 32'(dut.irq_status),     32'(m_stat));
    chk({t, ".irq"},    32'(irq),                32'(m_stat != '0));
    chk({t, ".empty"},  32'(bus.rd_fifo_empty),  32'(q.size() == 0));
    chk({t, ".full"},   32'(bus.rd_fifo_full),   32'(q.size() == DEPTH));
    chk({t, ".data"},   32'(bus.rd_fifo_data),   32'(m_data));
    chk({t, ".err"},    32'(cmd_err),            32'(m_err));
    chk({t, ".ovf"},    32'(rd_ovf),             32'(m_ovf));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  b;
    logic [15:0] pl;
    int          r;

    bus.cmd_wr_en  = 1'b0;
    bus.cmd_byte   = '0;
    bus.rd_fifo_en = 1'b0;
    gpio_in        = '0;
    pins           = '0;
    model_reset();
    idle(2);
    check_all("reset");
    rst_n = 1'b1;
    idle(3);

    // T1: OE then OUT, each visible one cycle after EXEC
    send(8'h02); send(8'hFF); put(8'h0F);
    chk("t1.oe_in_exec", 32'(gpio_oe), 32'h000);
    step();
    chk("t1.oe_after", 32'(gpio_oe), 32'hFFF);
    step();
    send(8'h01); send(8'h5A); put(8'h03);
    chk("t1.out_in_exec", 32'(gpio_out), 32'h000);
    step();
    chk("t1.out_after", 32'(gpio_out), 32'h35A);
    step();
    m_oe = 12'hFFF; m_out = 12'h35A;
    check_all("t1");

    // T2: snapshot 0xABC -> 0xBC, 0x0A
    set_pins(12'hABC);
    snap();
    check_all("t2.pushed");
    pop();
    chk("t2.pop0", 32'(bus.rd_fifo_data), 32'hBC);
    pop();
    chk("t2.pop1", 32'(bus.rd_fifo_data), 32'h0A);
    chk("t2.empty", 32'(bus.rd_fifo_empty), 32'h1);
    pop();
    check_all("t2.pop_empty");

    // T3: rise on pin0, fall on pin11, then partial IRQ_CLR
    do_cmd(8'h03, 16'h0001);
    do_cmd(8'h04, 16'h0800);
    gpio_in = pins | 12'h001;
    idle(2);
    chk("t3.lat2", 32'(dut.irq_status), 32'h000);
    step();
    chk("t3.lat3", 32'(dut.irq_status), 32'h001);
    chk("t3.irq_lag", 32'(irq), 32'h0);
    step();
    chk("t3.irq_set", 32'(irq), 32'h1);
    pins = gpio_in; m_stat = m_stat | 12'h001;
    idle(2);
    set_pins(pins & ~12'h800);
    chk("t3.status", 32'(dut.irq_status), 32'h801);
    do_cmd(8'h05, 16'h0001);
    chk("t3.cleared", 32'(dut.irq_status), 32'h800);
    check_all("t3");

    // T4: overfill the 4-byte FIFO, then a snapshot while the pusher is busy
    snap(); snap(); snap();
    chk("t4.full", 32'(bus.rd_fifo_full), 32'h1);
    chk("t4.ovf", 32'(rd_ovf), 32'h1);
    check_all("t4.fill");
    put(8'h06);
    put(8'h06);
    idle(3);
    model_snap();
    m_err = 1'b1;
    chk("t4.busy_err", 32'(cmd_err), 32'h1);
    check_all("t4.busy");
    for (int i = 0; i < DEPTH; i++) begin
      pop();
      check_all($sformatf("t4.pop%0d", i));
    end

    // T5: bad opcode, command still works, ERR_CLR
    send(8'h07); m_err = 1'b0; m_ovf = 1'b0;
    check_all("t5.clr0");
    send(8'h3C); m_err = 1'b1;
    chk("t5.bad", 32'(cmd_err), 32'h1);
    do_cmd(8'h01, 16'h0000);
    check_all("t5.exec");
    send(8'h07); m_err = 1'b0; m_ovf = 1'b0;
    check_all("t5.clr1");

    // T6: reset mid-payload
    send(8'h01);
    put(8'h11);
    rst_n = 1'b0;
    idle(1);
    model_reset();
    check_all("t6.rst");
    rst_n = 1'b1;
    idle(3);
    do_cmd(8'h01, 16'h0022);
    chk("t6.out", 32'(gpio_out), 32'h022);
    check_all("t6");

    // Randomized command mix against the model
    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 7));
      case (r)
        0, 1: begin
          b  = 8'($urandom_range(1, 5));
          pl = 16'($urandom);
          do_cmd(b, pl);
        end
        2: set_pins(GW'($urandom));
        3: snap();
        4, 5: pop();
        6: begin
          b = 8'($urandom_range(8, 255));
          send(b);
          m_err = 1'b1;
        end
        default: begin
          send(8'h07);
          m_err = 1'b0;
          m_ovf = 1'b0;
        end
      endcase
      check_all($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
